// File: rtl/sme_match_collector_if.sv
// SME match-report bundle: report inputs, result stream and status counters.
// slave is the collector's view, master is the SME/host view.
interface sme_match_collector_if #(
  parameter int DEPTH = 256
);
  logic                     valid;
  logic [3:0]               pattern_no;
  logic [11:0]              match_addr;
  logic                     finish;
  logic                     out_valid;
  logic [15:0]              out_data;
  logic                     out_ready;
  logic                     done;
  logic                     busy;
  logic [$clog2(DEPTH):0]   uniq_cnt;
  logic [15:0]              dup_cnt;
  logic [15:0]              drop_cnt;

  modport slave (
    input  valid, pattern_no, match_addr, finish, out_ready,
    output out_valid, out_data, done, busy, uniq_cnt, dup_cnt, drop_cnt
  );

  modport master (
    output valid, pattern_no, match_addr, finish, out_ready,
    input  out_valid, out_data, done, busy, uniq_cnt, dup_cnt, drop_cnt
  );
endinterface

// File: rtl/sme_match_collector.sv
// Buffers SME match reports, stores them in first-arrival order and streams them out
// after finish. Define MATCH_DEDUP_EN to build the SCAN state that discards repeats.
module sme_match_collector #(
  parameter int DEPTH      = 256,
  parameter int FIFO_DEPTH = 8
) (
  input logic                  clk,
  input logic                  reset,
  sme_match_collector_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0]  DEPTH_C = DEPTH[CW-1:0];
  localparam logic [FAW:0]   FDEPTH  = FIFO_DEPTH[FAW:0];

  typedef enum logic [2:0] {
    IDLE, INSERT, DRAIN, DONE
`ifdef MATCH_DEDUP_EN
    , SCAN
`endif
  } state_e;

  state_e          state_q;
  logic            finish_seen_q;
  logic [15:0]     fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FAW:0]    fcnt_q;
  logic [15:0]     mem [DEPTH];
  logic [15:0]     cand_q;
  logic [CW-1:0]   uniq_cnt_q;
  logic [AW-1:0]   rd_idx_q, rd_idx_nxt;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [16:0]     drop_sum;
  logic            out_valid_q, done_q;
  logic [15:0]     out_data_q;
`ifdef MATCH_DEDUP_EN
  logic [AW-1:0]   idx_q;
  logic [15:0]     dup_cnt_q;
`endif

  logic accept, push, pop, fifo_drop, fifo_empty, tbl_full, tbl_drop, last_xfer;

  // Reports after finish_seen are neither stored nor counted as drops.
  assign accept     = bus.valid & ~finish_seen_q;
  assign push       = accept & (fcnt_q < FDEPTH);
  assign fifo_drop  = accept & ~push;
  assign fifo_empty = (fcnt_q == '0);
  assign pop        = (state_q == IDLE) & ~fifo_empty;
  assign tbl_full   = (uniq_cnt_q == DEPTH_C);
  assign tbl_drop   = (state_q == INSERT) & tbl_full;
  assign last_xfer  = ({1'b0, rd_idx_q} == uniq_cnt_q - CW'(1));
  assign rd_idx_nxt = rd_idx_q + AW'(1);

  // Both drop sources can fire in one cycle, so the saturating add takes up to 2.
  assign drop_sum   = {1'b0, drop_cnt_q} + {16'b0, fifo_drop} + {16'b0, tbl_drop};
  assign drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {bus.pattern_no, bus.match_addr};
  end

  always_ff @(posedge clk) begin
    if ((state_q == INSERT) && !tbl_full) mem[uniq_cnt_q[AW-1:0]] <= cand_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      finish_seen_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fcnt_q        <= '0;
      cand_q        <= '0;
      uniq_cnt_q    <= '0;
      rd_idx_q      <= '0;
      drop_cnt_q    <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      done_q        <= 1'b0;
`ifdef MATCH_DEDUP_EN
      idx_q         <= '0;
      dup_cnt_q     <= '0;
`endif
    end else begin
      if (bus.finish) finish_seen_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + FAW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FAW'(1);
      fcnt_q     <= fcnt_q + {{FAW{1'b0}}, push} - {{FAW{1'b0}}, pop};
      drop_cnt_q <= drop_cnt_d;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            cand_q <= fifo_mem[rd_ptr_q];
`ifdef MATCH_DEDUP_EN
            idx_q   <= '0;
            state_q <= (uniq_cnt_q != '0) ? SCAN : INSERT;
`else
            state_q <= INSERT;
`endif
          end else if (finish_seen_q) begin
            rd_idx_q <= '0;
            if (uniq_cnt_q == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= DRAIN;
              out_valid_q <= 1'b1;
              out_data_q  <= mem[AW'(0)];
            end
          end
        end
`ifdef MATCH_DEDUP_EN
        SCAN: begin
          if (mem[idx_q] == cand_q) begin
            if (dup_cnt_q != 16'hFFFF) dup_cnt_q <= dup_cnt_q + 16'd1;
            state_q <= IDLE;
          end else if ({1'b0, idx_q} == uniq_cnt_q - CW'(1)) begin
            state_q <= INSERT;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
`endif
        INSERT: begin
          if (!tbl_full) uniq_cnt_q <= uniq_cnt_q + CW'(1);
          state_q <= IDLE;
        end
        DRAIN: begin
          // out_data only moves on a completed handshake, so it is stable under stall.
          if (bus.out_ready) begin
            rd_idx_q <= rd_idx_nxt;
            if (last_xfer) begin
              state_q     <= DONE;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              out_data_q <= mem[rd_idx_nxt];
            end
          end
        end
        DONE:    done_q  <= 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.done      = done_q;
  assign bus.busy      = ((state_q != IDLE) && (state_q != DONE)) || !fifo_empty;
  assign bus.uniq_cnt  = uniq_cnt_q;
  assign bus.drop_cnt  = drop_cnt_q;
`ifdef MATCH_DEDUP_EN
  assign bus.dup_cnt   = dup_cnt_q;
`else
  assign bus.dup_cnt   = '0;
`endif
endmodule

// File: tb/tb_sme_match_collector.sv
// Directed bench for sme_match_collector: two instances (DEPTH=4 table, FIFO_DEPTH=4 FIFO)
// share one stimulus bus; sel picks which instance the checks observe.
module tb_sme_match_collector;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid, finish, out_ready, sel;
  logic [15:0] word;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  logic        o_valid, o_done, o_busy;
  logic [15:0] o_data, o_dup, o_drop;
  logic [7:0]  o_uniq;

  sme_match_collector_if #(.DEPTH(4))  ia ();
  sme_match_collector_if #(.DEPTH(16)) ib ();

  sme_match_collector #(.DEPTH(4), .FIFO_DEPTH(8)) u_a (.clk(clk), .reset(rst), .bus(ia));
  sme_match_collector #(.DEPTH(16), .FIFO_DEPTH(4)) u_b (.clk(clk), .reset(rst), .bus(ib));

  assign ia.valid = valid;
  assign ia.finish = finish;
  assign ia.out_ready = out_ready;
  assign {ia.pattern_no, ia.match_addr} = word;
  assign ib.valid = valid;
  assign ib.finish = finish;
  assign ib.out_ready = out_ready;
  assign {ib.pattern_no, ib.match_addr} = word;

  always_comb begin
    if (sel) begin
      o_valid = ib.out_valid; o_done = ib.done; o_busy = ib.busy; o_data = ib.out_data;
      o_dup = ib.dup_cnt; o_drop = ib.drop_cnt; o_uniq = 8'(ib.uniq_cnt);
    end else begin
      o_valid = ia.out_valid; o_done = ia.done; o_busy = ia.busy; o_data = ia.out_data;
      o_dup = ia.dup_cnt; o_drop = ia.drop_cnt; o_uniq = 8'(ia.uniq_cnt);
    end
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ovalid"}, o_valid, 0);
    chk({tag, "_odata"},  o_data,  0);
    chk({tag, "_done"},   o_done,  0);
    chk({tag, "_busy"},   o_busy,  0);
    chk({tag, "_uniq"},   o_uniq,  0);
    chk({tag, "_dup"},    o_dup,   0);
    chk({tag, "_drop"},   o_drop,  0);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; finish = 1'b0; word = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] w);
    @(negedge clk); valid = 1'b1; word = w;
    @(negedge clk); valid = 1'b0;
  endtask

  task automatic fin();
    @(negedge clk); finish = 1'b1;
    @(negedge clk); finish = 1'b0;
  endtask

  // Accepts words until done; stalls 5 cycles once stall_at words are in, or stops at abort_at.
  task automatic collect(input int budget, input int stall_at, input int abort_at);
    int          stall_left = 5;
    logic        pv = 1'b0, pr = 1'b0, r;
    logic [15:0] pd = '0;
    got_q.delete();
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (pv && !pr) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_data", o_data, pd);
      end
      if (o_done || got_q.size() == abort_at) break;
      r = 1'b1;
      if (got_q.size() == stall_at && stall_left > 0) begin
        r = 1'b0;
        stall_left--;
      end
      out_ready = r;
      if (o_valid && r) got_q.push_back(o_data);
      pv = o_valid; pr = r; pd = o_data;
    end
    if (abort_at < 0) chk("done", o_done, 1);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int dropi;
    rst = 1'b1; sel = 1'b0; valid = 1'b0; finish = 1'b0; word = '0; out_ready = 1'b1;
    do_reset();
    #1 chk_reset("rstA");
    sel = 1'b1;
    #1 chk_reset("rstB");

    // single report, with store latency
    send(16'h301A);
    chk("t1_busy", o_busy, 1);
    idle(1); chk("t1_uniq_n1", o_uniq, 0);
    idle(1); chk("t1_uniq_n2", o_uniq, 1);
    idle(2); fin();
    collect(50, -1, -1);
    exp_q = '{16'h301A};
    cmp_stream("t1");
    chk("t1_uniq", o_uniq, 1);
    chk("t1_dup", o_dup, 0);
    chk("t1_busy_done", o_busy, 0);
    chk("t1_ovalid_done", o_valid, 0);

    // duplicates; last report shares a cycle with finish, the next one is ignored
    do_reset();
    send(16'h2005); idle(2); send(16'h2005); idle(2); send(16'h2005); idle(2);
    @(negedge clk); valid = 1'b1; word = 16'h2006; finish = 1'b1;
    @(negedge clk); finish = 1'b0; word = 16'h2FFF;
    @(negedge clk); valid = 1'b0;
    collect(100, -1, -1);
`ifdef MATCH_DEDUP_EN
    exp_q = '{16'h2005, 16'h2006};
    cmp_stream("t2");
    chk("t2_uniq", o_uniq, 2);
    chk("t2_dup", o_dup, 2);
`else
    exp_q = '{16'h2005, 16'h2005, 16'h2005, 16'h2006};
    cmp_stream("t2");
    chk("t2_uniq", o_uniq, 4);
    chk("t2_dup", o_dup, 0);
`endif
    chk("t2_drop", o_drop, 0);

    // FIFO overflow on the FIFO_DEPTH=4 instance
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); valid = 1'b1; word = 16'h3A00 + 16'(i);
    end
    @(negedge clk); valid = 1'b0;
`ifdef MATCH_DEDUP_EN
    dropi = 6;
`else
    dropi = 7;
`endif
    idle(80); fin();
    collect(100, -1, -1);
    exp_q.delete();
    for (int i = 0; i < 8; i++) if (i != dropi) exp_q.push_back(16'h3A00 + 16'(i));
    cmp_stream("t3");
    chk("t3_drop", o_drop, 1);
    chk("t3_uniq", o_uniq, 7);

    // table full on the DEPTH=4 instance
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(16'h4100 + 16'(i)); idle(8);
    end
    fin();
    collect(100, -1, -1);
    exp_q = '{16'h4100, 16'h4101, 16'h4102, 16'h4103};
    cmp_stream("t4");
    chk("t4_uniq", o_uniq, 4);
    chk("t4_drop", o_drop, 2);

    // backpressure after two transfers
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(16'h5000 + 16'h0011 * 16'(i)); idle(6);
    end
    idle(10); fin();
    collect(200, 2, -1);
    exp_q = '{16'h5000, 16'h5011, 16'h5022, 16'h5033, 16'h5044};
    cmp_stream("t5");
    chk("t5_uniq", o_uniq, 5);

    // reset mid-drain, then a fresh collection
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(16'h6000 + 16'(i)); idle(6);
    end
    idle(10); fin();
    collect(200, -1, 2);
    chk("t6_pre_len", got_q.size(), 2);
    chk("t6_mid_valid", o_valid, 1);
    rst = 1'b1;
    #1 chk_reset("t6rst");
    @(negedge clk); rst = 1'b0;
    send(16'h6A01); idle(2); send(16'h6A02); idle(10);
    fin();
    collect(100, -1, -1);
    exp_q = '{16'h6A01, 16'h6A02};
    cmp_stream("t6");
    chk("t6_uniq", o_uniq, 2);
    chk("t6_drop", o_drop, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
